// File: rtl/game_pkg.sv
// Shared 2048 game constants: move direction codes, one-hot key bus values
// and the direction-to-key decode used by the key sequencer.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [3:0] KEY_UP    = 4'b1000;
  localparam logic [3:0] KEY_DOWN  = 4'b0100;
  localparam logic [3:0] KEY_LEFT  = 4'b0010;
  localparam logic [3:0] KEY_RIGHT = 4'b0001;
  localparam logic [3:0] KEY_NONE  = 4'b0000;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_PRESS   = 2'd1,
    SEQ_RELEASE = 2'd2
  } seq_state_e;

  function automatic logic [3:0] dir_to_key(input logic [1:0] dir);
    logic [3:0] key;
    case (dir)
      DIR_UP:   key = KEY_UP;
      DIR_DOWN: key = KEY_DOWN;
      DIR_LEFT: key = KEY_LEFT;
      default:  key = KEY_RIGHT;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/key_sequencer_fifo.sv
// Small synchronous FIFO of 2-bit move codes feeding the key sequencer.
// Pushes while full and pops while empty are ignored.
module move_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_game,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    din,
  output logic [1:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_game) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_game or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/key_sequencer.sv
// Replays queued moves on the one-hot key bus with press/hold/release timing;
// manual keys pass through (registered) while the sequencer is idle.
module key_sequencer
  import game_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 4
) (
  input  logic                     clk_game,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [1:0]               wr_dir,
  output logic                     wr_ready,
  input  logic                     enable,
  input  logic [3:0]               manual_key,
  output logic [3:0]               key_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int TMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  seq_state_e    state;
  logic [TW-1:0] tmr;
  logic [1:0]    head;
  logic          push, start, fifo_full, fifo_empty;

  assign wr_ready = (count != CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  // A held manual key blocks a generated press from starting.
  assign start    = (state == SEQ_IDLE) && enable && !fifo_empty &&
                    (manual_key == KEY_NONE);

  move_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_game (clk_game),
    .rst      (rst),
    .push     (push),
    .pop      (start),
    .din      (wr_dir),
    .dout     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_game or posedge rst) begin
    if (rst) begin
      state   <= SEQ_IDLE;
      tmr     <= '0;
      key_out <= KEY_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            key_out <= dir_to_key(head);
            tmr     <= TW'(HOLD_CYC);
            busy    <= 1'b1;
            state   <= SEQ_PRESS;
          end else begin
            key_out <= manual_key;
            busy    <= 1'b0;
          end
        end
        SEQ_PRESS: begin
          if (tmr == TW'(1)) begin
            key_out <= KEY_NONE;
            tmr     <= TW'(GAP_CYC);
            state   <= SEQ_RELEASE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        SEQ_RELEASE: begin
          if (tmr == TW'(1)) begin
            busy  <= 1'b0;
            done  <= fifo_empty && !push;
            state <= SEQ_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          key_out <= KEY_NONE;
          busy    <= 1'b0;
          state   <= SEQ_IDLE;
        end
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer: directed table, hand-written corner
// sequences and random traffic against a queue/phase-based reference model.
module tb_key_sequencer;
  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int GAP   = 4;

  logic       clk_game = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_dir = 2'd0;
  logic       wr_ready;
  logic       enable = 1'b0;
  logic [3:0] manual_key = 4'd0;
  logic [3:0] key_out;
  logic       busy;
  logic [4:0] count;
  logic       done;

  key_sequencer #(.DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .clk_game   (clk_game),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_dir     (wr_dir),
    .wr_ready   (wr_ready),
    .enable     (enable),
    .manual_key (manual_key),
    .key_out    (key_out),
    .busy       (busy),
    .count      (count),
    .done       (done)
  );

  always #5 clk_game = ~clk_game;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of moves plus the number of cycles elapsed
  // since the current press started (-1 when nothing is being played).
  logic [1:0] mq[$];
  int         ph = -1;
  logic [3:0] m_cur = 4'd0;
  logic [3:0] m_key = 4'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  function automatic logic [3:0] ref_key(input logic [1:0] d);
    logic [3:0] k;
    k = 4'b1000;
    return k >> d;
  endfunction

  task automatic model_reset();
    mq.delete();
    ph = -1; m_cur = 0; m_key = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit pushed;
    int sz;
    sz     = mq.size();
    pushed = wr_valid && (sz < DEPTH);
    m_done = 1'b0;
    if (ph < 0) begin
      if (enable && sz != 0 && manual_key == 4'd0) begin
        m_cur = ref_key(mq.pop_front());
        ph = 0; m_key = m_cur; m_busy = 1'b1;
      end else begin
        m_key = manual_key; m_busy = 1'b0;
      end
    end else begin
      ph++;
      if (ph < HOLD) m_key = m_cur;
      else if (ph < HOLD + GAP) m_key = 4'd0;
      else begin
        ph = -1; m_key = 4'd0; m_busy = 1'b0;
        m_done = (sz == 0) && !pushed;
      end
    end
    if (pushed) mq.push_back(wr_dir);
  endtask

  task automatic check_all(input string nm);
    int mc;
    mc = mq.size();
    checks++;
    if (key_out !== m_key || busy !== m_busy || done !== m_done ||
        count !== 5'(mc) || wr_ready !== (mc != DEPTH)) begin
      errors++;
      $display("FAIL %s t=%0t: key=%b busy=%b done=%b count=%0d rdy=%b, expected key=%b busy=%b done=%b count=%0d rdy=%b",
               nm, $time, key_out, busy, done, count, wr_ready,
               m_key, m_busy, m_done, mc, (mc != DEPTH));
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input string nm);
    @(posedge clk_game);
    model_edge();
    #1;
    check_all(nm);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 0; enable = 0; manual_key = 0;
    @(posedge clk_game); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       wv;
    logic [1:0] dir;
    logic       en;
    logic [3:0] mk;
    logic [3:0] ek;
    logic       eb;
    logic       ed;
    int         ec;
  } vec_t;

  vec_t tbl[13];
  int   presses;

  initial begin
    // Single left move, then manual pass-through; expected values after each edge.
    tbl[0]  = '{1, 2'd2, 0, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[1]  = '{0, 2'd0, 1, 4'b0000, 4'b0010, 1, 0, 0};
    tbl[2]  = '{0, 2'd0, 1, 4'b0000, 4'b0010, 1, 0, 0};
    tbl[3]  = '{0, 2'd0, 1, 4'b0000, 4'b0010, 1, 0, 0};
    tbl[4]  = '{0, 2'd0, 1, 4'b0000, 4'b0010, 1, 0, 0};
    tbl[5]  = '{0, 2'd0, 1, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[6]  = '{0, 2'd0, 1, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[7]  = '{0, 2'd0, 1, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[8]  = '{0, 2'd0, 1, 4'b0000, 4'b0000, 1, 0, 0};
    tbl[9]  = '{0, 2'd0, 1, 4'b0000, 4'b0000, 0, 1, 0};
    tbl[10] = '{0, 2'd0, 1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[11] = '{0, 2'd0, 0, 4'b0100, 4'b0100, 0, 0, 0};
    tbl[12] = '{0, 2'd0, 0, 4'b0000, 4'b0000, 0, 0, 0};

    #2;
    check_val("reset key_out", int'(key_out), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset count", int'(count), 0);
    check_val("reset wr_ready", int'(wr_ready), 1);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      wr_valid = tbl[i].wv; wr_dir = tbl[i].dir;
      enable = tbl[i].en; manual_key = tbl[i].mk;
      step("table model");
      checks++;
      if (key_out !== tbl[i].ek || busy !== tbl[i].eb || done !== tbl[i].ed ||
          count !== 5'(tbl[i].ec)) begin
        errors++;
        $display("FAIL table[%0d]: key=%b busy=%b done=%b count=%0d, expected key=%b busy=%b done=%b count=%0d",
                 i, key_out, busy, done, count, tbl[i].ek, tbl[i].eb, tbl[i].ed, tbl[i].ec);
      end
    end

    // Three back-to-back moves: up, down, right.
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_dir = (i == 2) ? 2'd3 : 2'(i);
      step("burst push");
    end
    wr_valid = 0;
    for (int i = 0; i < 30; i++) step("burst play");

    // Fill queue with enable low; 17th push must be dropped.
    enable = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_valid = 1; wr_dir = 2'($urandom_range(0, 3));
      step("fill");
    end
    wr_valid = 0;
    check_val("full count", int'(count), DEPTH);
    check_val("full wr_ready", int'(wr_ready), 0);
    enable = 1;
    presses = 0;
    for (int i = 0; i < DEPTH * (HOLD + GAP + 1) + 4; i++) begin
      step("drain");
      if (ph == 0) presses++;
    end
    check_val("drain presses", presses, DEPTH);
    check_val("drain count", int'(count), 0);

    // Manual key held blocks start until released.
    enable = 0; manual_key = 4'b0100;
    step("manual pass");
    check_val("manual latency", int'(key_out), 4'b0100);
    wr_valid = 1; wr_dir = 2'd1; step("manual push");
    wr_valid = 0; enable = 1;
    for (int i = 0; i < 5; i++) step("manual hold");
    check_val("manual blocks start", int'(busy), 0);
    manual_key = 0;
    for (int i = 0; i < 12; i++) step("manual release");

    // Manual key and enable drop during PRESS: press completes, stays idle.
    enable = 0;
    wr_valid = 1; wr_dir = 2'd3; step("mid push a");
    wr_dir = 2'd0; step("mid push b");
    wr_valid = 0; enable = 1; step("mid start");
    manual_key = 4'b1000; enable = 0;
    for (int i = 0; i < 12; i++) step("mid press");
    check_val("mid idle busy", int'(busy), 0);
    check_val("mid idle count", int'(count), 1);
    manual_key = 0;
    step("mid clear");

    // Async reset during the second PRESS cycle.
    enable = 1; step("rst start");
    check_val("rst pressing", int'(busy), 1);
    step("rst press2");
    #2 rst = 1'b1;
    #1;
    check_val("async key_out", int'(key_out), 0);
    check_val("async count", int'(count), 0);
    check_val("async wr_ready", int'(wr_ready), 1);
    enable = 0;
    @(posedge clk_game); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step("post reset");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_dir = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      manual_key = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
